// File: rtl/grid_update_sequencer_pkg.sv
// rtl/grid_update_sequencer_pkg.sv - shared types and instruction layout for the grid update sequencer
//
// Purpose: operation and state enums, default coordinate width and the
// field positions inside a packed instruction word
// {last, valid, op[1:0], start_row, start_col, end_row, end_col}.
// Ports: none (package).
package grid_update_sequencer_pkg;

  localparam int POSITION_WIDTH = 12;

  // Command operations as seen on cmd_op.
  typedef enum logic [1:0] {
    OP_OFF    = 2'b00,
    OP_TOGGLE = 2'b01,
    OP_COUNT  = 2'b10,
    OP_ON     = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_SWEEP = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  // Coordinate fields are counted from the LSB in units of the coordinate
  // width, so the layout scales with POSITION_WIDTH.
  localparam int FIELD_END_COL   = 0;
  localparam int FIELD_END_ROW   = 1;
  localparam int FIELD_START_COL = 2;
  localparam int FIELD_START_ROW = 3;
  localparam int FIELD_OP        = 4;

  // Flag bits are counted down from the MSB of the instruction word.
  localparam int LAST_FROM_TOP  = 1;
  localparam int VALID_FROM_TOP = 2;

endpackage

// File: rtl/grid_update_sequencer_range_normaliser.sv
// rtl/grid_update_sequencer_range_normaliser.sv - orders a coordinate pair and clamps it to the grid
//
// Purpose: combinational min/max swap of two coordinates followed by a clamp
// of both ends to GRID_SIZE-1.
// Ports:
//   a, b   in  POSITION_WIDTH  raw coordinates in any order
//   lo, hi out POSITION_WIDTH  ordered, clamped range
module range_normaliser #(
  parameter int POSITION_WIDTH = 12,
  parameter int GRID_SIZE      = 1000
) (
  input  logic [POSITION_WIDTH-1:0] a,
  input  logic [POSITION_WIDTH-1:0] b,
  output logic [POSITION_WIDTH-1:0] lo,
  output logic [POSITION_WIDTH-1:0] hi
);

  localparam logic [POSITION_WIDTH-1:0] GRID_MAX = POSITION_WIDTH'(GRID_SIZE - 1);

  logic [POSITION_WIDTH-1:0] min_v;
  logic [POSITION_WIDTH-1:0] max_v;

  always_comb begin
    min_v = (a < b) ? a : b;
    max_v = (a < b) ? b : a;
    // Clamping is monotone, so clamping after ordering keeps lo <= hi.
    lo    = (min_v > GRID_MAX) ? GRID_MAX : min_v;
    hi    = (max_v > GRID_MAX) ? GRID_MAX : max_v;
  end

endmodule

// File: rtl/grid_update_sequencer.sv
// rtl/grid_update_sequencer.sv - expands rectangle instructions into per-row light grid commands
//
// Purpose: accepts packed rectangle instructions, issues one command per row
// of the normalised rectangle, and on end of file performs a full-grid count
// sweep before parking in DONE until reset.
// Optional build macro: GRID_SEQUENCER_STATS_EN adds saturating statistics
// outputs instr_count and cmd_count.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   instr_valid/ready/data     instruction input handshake
//   end_of_file                level-sampled end of instruction stream
//   cmd_valid/ready            command output handshake
//   cmd_op                     00 off, 01 toggle, 11 on, 10 count
//   cmd_row, cmd_col_lo/hi     row and inclusive column range of the command
//   busy                       high while issuing or sweeping
//   done                       high once the sweep has finished
//   instr_count, cmd_count     (stats build only) accepted instructions, command handshakes
module grid_update_sequencer
  import grid_update_sequencer_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH = 52,
  parameter int POSITION_WIDTH    = grid_update_sequencer_pkg::POSITION_WIDTH,
  parameter int GRID_SIZE         = 1000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         instr_valid,
  output logic                         instr_ready,
  input  logic [INSTRUCTION_WIDTH-1:0] instr_data,
  input  logic                         end_of_file,
  output logic                         cmd_valid,
  input  logic                         cmd_ready,
  output logic [1:0]                   cmd_op,
  output logic [POSITION_WIDTH-1:0]    cmd_row,
  output logic [POSITION_WIDTH-1:0]    cmd_col_lo,
  output logic [POSITION_WIDTH-1:0]    cmd_col_hi,
  output logic                         busy,
  output logic                         done
`ifdef GRID_SEQUENCER_STATS_EN
  ,
  output logic [15:0]                  instr_count,
  output logic [23:0]                  cmd_count
`endif
);

  localparam int VALID_BIT = INSTRUCTION_WIDTH - VALID_FROM_TOP;
  localparam int LAST_BIT  = INSTRUCTION_WIDTH - LAST_FROM_TOP;
  localparam logic [POSITION_WIDTH-1:0] GRID_MAX = POSITION_WIDTH'(GRID_SIZE - 1);

  // Raw instruction fields.
  logic [POSITION_WIDTH-1:0] start_row;
  logic [POSITION_WIDTH-1:0] start_col;
  logic [POSITION_WIDTH-1:0] end_row;
  logic [POSITION_WIDTH-1:0] end_col;
  logic [1:0]                instr_op;
  logic                      instr_is_valid;
  logic                      instr_is_last;

  assign start_row      = instr_data[FIELD_START_ROW*POSITION_WIDTH +: POSITION_WIDTH];
  assign start_col      = instr_data[FIELD_START_COL*POSITION_WIDTH +: POSITION_WIDTH];
  assign end_row        = instr_data[FIELD_END_ROW*POSITION_WIDTH +: POSITION_WIDTH];
  assign end_col        = instr_data[FIELD_END_COL*POSITION_WIDTH +: POSITION_WIDTH];
  assign instr_op       = instr_data[FIELD_OP*POSITION_WIDTH +: 2];
  assign instr_is_valid = instr_data[VALID_BIT];
  assign instr_is_last  = instr_data[LAST_BIT];

  // Normalised ranges of the instruction currently on the input bus.
  logic [POSITION_WIDTH-1:0] row_lo_n;
  logic [POSITION_WIDTH-1:0] row_hi_n;
  logic [POSITION_WIDTH-1:0] col_lo_n;
  logic [POSITION_WIDTH-1:0] col_hi_n;

  range_normaliser #(
    .POSITION_WIDTH(POSITION_WIDTH),
    .GRID_SIZE     (GRID_SIZE)
  ) u_row_norm (
    .a (start_row),
    .b (end_row),
    .lo(row_lo_n),
    .hi(row_hi_n)
  );

  range_normaliser #(
    .POSITION_WIDTH(POSITION_WIDTH),
    .GRID_SIZE     (GRID_SIZE)
  ) u_col_norm (
    .a (start_col),
    .b (end_col),
    .lo(col_lo_n),
    .hi(col_hi_n)
  );

  // Sequencer state and datapath registers.
  seq_state_e                state;
  seq_state_e                state_next;
  logic [POSITION_WIDTH-1:0] row_q;
  logic [POSITION_WIDTH-1:0] row_hi_q;
  logic [POSITION_WIDTH-1:0] col_lo_q;
  logic [POSITION_WIDTH-1:0] col_hi_q;
  op_e                       op_q;
  logic                      last_q;
  logic                      eof_pending_q;

  logic                      last_row;
  logic                      advance;
  logic                      load_instr;
  logic                      start_sweep;

  // Both ISSUE and SWEEP finish on the handshake of row_hi_q; SWEEP loads
  // row_hi_q with GRID_SIZE-1 so one equality compare serves both.
  assign last_row    = (row_q == row_hi_q);
  assign advance     = cmd_valid & cmd_ready;
  assign load_instr  = (state == ST_IDLE) & instr_valid & instr_is_valid;
  assign start_sweep = (state_next == ST_SWEEP) & (state != ST_SWEEP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    instr_ready = 1'b0;
    cmd_valid   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      ST_IDLE: begin
        instr_ready = 1'b1;
        // An instruction always wins over a simultaneous EOF; the EOF is
        // latched and honoured once the instruction has been issued.
        if (instr_valid) begin
          if (instr_is_valid) begin
            state_next = ST_ISSUE;
          end
        end else if (end_of_file || eof_pending_q) begin
          state_next = ST_SWEEP;
        end
      end
      ST_ISSUE: begin
        busy      = 1'b1;
        cmd_valid = 1'b1;
        if (cmd_ready && last_row) begin
          if (eof_pending_q || end_of_file || last_q) begin
            state_next = ST_SWEEP;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_SWEEP: begin
        busy      = 1'b1;
        cmd_valid = 1'b1;
        if (cmd_ready && last_row) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_q    <= '0;
      row_hi_q <= '0;
      col_lo_q <= '0;
      col_hi_q <= '0;
      op_q     <= OP_OFF;
      last_q   <= 1'b0;
    end else if (load_instr) begin
      row_q    <= row_lo_n;
      row_hi_q <= row_hi_n;
      col_lo_q <= col_lo_n;
      col_hi_q <= col_hi_n;
      op_q     <= op_e'(instr_op);
      last_q   <= instr_is_last;
    end else if (start_sweep) begin
      row_q    <= '0;
      row_hi_q <= GRID_MAX;
      col_lo_q <= '0;
      col_hi_q <= GRID_MAX;
      op_q     <= OP_COUNT;
      last_q   <= 1'b0;
    end else if (advance && !last_row) begin
      // Row only moves on a handshake and stops at row_hi_q, so it never wraps.
      row_q <= row_q + POSITION_WIDTH'(1);
    end
  end

  // EOF seen while an instruction is being accepted or issued is remembered
  // until the sweep actually starts. A dropped instruction with EOF also
  // leaves the flag set, so IDLE enters SWEEP on the following cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      eof_pending_q <= 1'b0;
    end else if (start_sweep) begin
      eof_pending_q <= 1'b0;
    end else if (end_of_file && (state == ST_IDLE || state == ST_ISSUE)) begin
      eof_pending_q <= 1'b1;
    end
  end

  assign cmd_op     = op_q;
  assign cmd_row    = row_q;
  assign cmd_col_lo = col_lo_q;
  assign cmd_col_hi = col_hi_q;

`ifdef GRID_SEQUENCER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_count <= '0;
      cmd_count   <= '0;
    end else begin
      if (load_instr && (instr_count != 16'hFFFF)) begin
        instr_count <= instr_count + 16'd1;
      end
      if (advance && (cmd_count != 24'hFFFFFF)) begin
        cmd_count <= cmd_count + 24'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_grid_update_sequencer.sv
// tb/tb_grid_update_sequencer.sv - self-checking bench for grid_update_sequencer
//
// Purpose: directed and randomized instructions compared against a
// rectangle-to-row-list reference model.
// Ports: none (testbench top).
module tb_grid_update_sequencer;

  localparam int IW = 52;
  localparam int PW = 12;
  localparam int GS = 1000;

  logic          clk = 1'b0;
  logic          reset;
  logic          instr_valid;
  logic          instr_ready;
  logic [IW-1:0] instr_data;
  logic          end_of_file;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [PW-1:0] cmd_row;
  logic [PW-1:0] cmd_col_lo;
  logic [PW-1:0] cmd_col_hi;
  logic          busy;
  logic          done;
`ifdef GRID_SEQUENCER_STATS_EN
  logic [15:0]   instr_count;
  logic [23:0]   cmd_count;
`endif

  always #5 clk = ~clk;

  grid_update_sequencer #(
    .INSTRUCTION_WIDTH(IW),
    .POSITION_WIDTH   (PW),
    .GRID_SIZE        (GS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_data (instr_data),
    .end_of_file(end_of_file),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_row    (cmd_row),
    .cmd_col_lo (cmd_col_lo),
    .cmd_col_hi (cmd_col_hi),
    .busy       (busy),
    .done       (done)
`ifdef GRID_SEQUENCER_STATS_EN
    ,
    .instr_count(instr_count),
    .cmd_count  (cmd_count)
`endif
  );

  typedef struct packed {
    logic [PW-1:0] row;
    logic [PW-1:0] lo;
    logic [PW-1:0] hi;
    logic [1:0]    op;
  } cmd_t;

  cmd_t exp_q[$];
  cmd_t obs_q[$];
  int   obs_cyc[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int hs_cyc  = 0;
  int ready_mode = 0;
  int stall_left = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, o, e);
    end
  endtask

  // Command monitor: records every handshake and checks that a stalled
  // command keeps its fields on the following cycle.
  logic stall_prev = 1'b0;
  cmd_t prev_cmd;
  cmd_t cur_cmd;
  always @(negedge clk) begin
    cur_cmd.row = cmd_row;
    cur_cmd.lo  = cmd_col_lo;
    cur_cmd.hi  = cmd_col_hi;
    cur_cmd.op  = cmd_op;
    if (!reset && stall_prev) begin
      check("stall_valid_held", 64'(cmd_valid), 64'(1));
      check("stall_fields_held", 64'(cur_cmd), 64'(prev_cmd));
    end
    if (!reset && cmd_valid && cmd_ready) begin
      obs_q.push_back(cur_cmd);
      obs_cyc.push_back(cyc);
    end
    stall_prev = !reset && cmd_valid && !cmd_ready;
    prev_cmd   = cur_cmd;
  end

  function automatic logic [IW-1:0] mk(input int last, input int valid, input int op,
                                       input int sr, input int sc, input int er, input int ec);
    return {1'(last), 1'(valid), 2'(op), 12'(sr), 12'(sc), 12'(er), 12'(ec)};
  endfunction

  function automatic int clampi(input int v);
    return (v >= GS) ? GS - 1 : v;
  endfunction

  // Reference: a valid rectangle becomes one command per covered row.
  task automatic model_instr(input logic [IW-1:0] d);
    int sr, sc, er, ec, rl, rh, cl, ch;
    cmd_t c;
    if (d[IW-2] == 1'b0) return;
    sr = int'(d[47:36]);
    sc = int'(d[35:24]);
    er = int'(d[23:12]);
    ec = int'(d[11:0]);
    rl = clampi((sr < er) ? sr : er);
    rh = clampi((sr < er) ? er : sr);
    cl = clampi((sc < ec) ? sc : ec);
    ch = clampi((sc < ec) ? ec : sc);
    for (int r = rl; r <= rh; r++) begin
      c.row = 12'(r);
      c.lo  = 12'(cl);
      c.hi  = 12'(ch);
      c.op  = d[49:48];
      exp_q.push_back(c);
    end
  endtask

  task automatic model_sweep(input int last_row);
    cmd_t c;
    for (int r = 0; r <= last_row; r++) begin
      c.row = 12'(r);
      c.lo  = 12'(0);
      c.hi  = 12'(GS - 1);
      c.op  = 2'b10;
      exp_q.push_back(c);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    case (ready_mode)
      0: cmd_ready = 1'b1;
      1: cmd_ready = 1'($urandom_range(0, 1));
      default: begin
        if (cmd_valid && cmd_row == 12'd2 && stall_left > 0) begin
          cmd_ready = 1'b0;
          stall_left--;
        end else begin
          cmd_ready = 1'b1;
        end
      end
    endcase
  endtask

  task automatic send(input logic [IW-1:0] d, input logic eof);
    instr_data  = d;
    instr_valid = 1'b1;
    end_of_file = eof;
    @(negedge clk);
    check("instr_ready_in_idle", 64'(instr_ready), 64'(1));
    hs_cyc = cyc;
    tick();
    instr_valid = 1'b0;
    end_of_file = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget, output int k);
    k = 0;
    while (!(busy == 1'b0 && instr_ready == 1'b1) && k < budget) begin
      tick();
      k++;
    end
    check(tag, 64'(k < budget), 64'(1));
  endtask

  task automatic compare_cmds(input string tag);
    int n;
    check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (obs_q[i] !== exp_q[i]) begin
        check({tag, "_cmd"}, 64'(obs_q[i]), 64'(exp_q[i]));
      end
    end
    if (n > 0) check({tag, "_last_cmd"}, 64'(obs_q[n-1]), 64'(exp_q[n-1]));
    obs_q.delete();
    obs_cyc.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_instr_ready"}, 64'(instr_ready), 64'(1));
    check({tag, "_cmd_valid"},   64'(cmd_valid),   64'(0));
    check({tag, "_busy"},        64'(busy),        64'(0));
    check({tag, "_done"},        64'(done),        64'(0));
    check({tag, "_fields"}, 64'({cmd_op, cmd_row, cmd_col_lo, cmd_col_hi}), 64'(0));
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IW-1:0] d;
    int k, sr, er, n;

    reset       = 1'b1;
    instr_valid = 1'b0;
    instr_data  = '0;
    end_of_file = 1'b0;
    cmd_ready   = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check_reset_state("reset");
    tick();
    reset = 1'b0;

    // On (1,2)-(3,4): rows 1..3 on consecutive cycles starting one after the handshake.
    ready_mode = 0;
    d = mk(0, 1, 3, 1, 2, 3, 4);
    model_instr(d);
    send(d, 1'b0);
    wait_idle("on_timeout", 100, k);
    check("on_cycles", 64'(k), 64'(3));
    if (obs_cyc.size() == 3) begin
      check("on_first_latency", 64'(obs_cyc[0] - hs_cyc), 64'(1));
      check("on_third_latency", 64'(obs_cyc[2] - hs_cyc), 64'(3));
    end
    compare_cmds("on");

    // Toggle (5,9)-(2,0): swapped coordinates.
    d = mk(0, 1, 1, 5, 9, 2, 0);
    model_instr(d);
    send(d, 1'b0);
    wait_idle("toggle_timeout", 100, k);
    check("toggle_cycles", 64'(k), 64'(4));
    compare_cmds("toggle");

    // Off (0,0)-(4,4) with three stall cycles on row 2.
    ready_mode = 2;
    stall_left = 3;
    d = mk(0, 1, 0, 0, 0, 4, 4);
    model_instr(d);
    send(d, 1'b0);
    wait_idle("stall_timeout", 100, k);
    check("stall_cycles", 64'(k), 64'(8));
    compare_cmds("stall");
    ready_mode = 0;

    // Clamp: end_row 1500, end_col 1200.
    d = mk(0, 1, 3, 995, 7, 1500, 1200);
    model_instr(d);
    send(d, 1'b0);
    wait_idle("clamp_timeout", 100, k);
    compare_cmds("clamp");

    // Valid bit clear: dropped.
    d = mk(0, 0, 3, 1, 1, 3, 3);
    send(d, 1'b0);
    repeat (4) tick();
    check("drop_busy", 64'(busy), 64'(0));
    compare_cmds("drop");

    // Randomized rectangles with random back-pressure.
    ready_mode = 1;
    for (int it = 0; it < 14; it++) begin
      sr = int'($urandom_range(0, 1100));
      er = sr + int'($urandom_range(0, 16)) - 8;
      if (er < 0) er = 0;
      d = mk(0, ($urandom_range(0, 5) != 0) ? 1 : 0, int'($urandom_range(0, 3)),
             sr, int'($urandom_range(0, 4095)), er, int'($urandom_range(0, 4095)));
      model_instr(d);
      send(d, 1'b0);
      wait_idle("rand_timeout", 2000, k);
      compare_cmds("rand");
    end

    // EOF pulsed during ISSUE: instruction completes, then full sweep, then DONE.
    d = mk(0, 1, 3, 0, 0, 2, 5);
    model_instr(d);
    model_sweep(GS - 1);
    send(d, 1'b0);
    end_of_file = 1'b1;
    tick();
    end_of_file = 1'b0;
    k = 0;
    while (!done && k < 20000) begin
      tick();
      k++;
    end
    check("sweep_timeout", 64'(k < 20000), 64'(1));
    compare_cmds("eof_sweep");
    @(negedge clk);
    check("done_flag", 64'({done, busy, cmd_valid, instr_ready}), 64'(4'b1000));
    instr_valid = 1'b1;
    instr_data  = mk(0, 1, 3, 0, 0, 0, 0);
    repeat (5) tick();
    instr_valid = 1'b0;
    check("done_held", 64'({done, busy, cmd_valid, instr_ready}), 64'(4'b1000));
    check("done_no_cmds", 64'(obs_q.size()), 64'(0));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("reset_after_done");
    obs_q.delete();
    obs_cyc.delete();

    // EOF in IDLE with no instruction: SWEEP starts on the next cycle.
    ready_mode = 0;
    end_of_file = 1'b1;
    tick();
    end_of_file = 1'b0;
    check("idle_eof_sweep", 64'({busy, cmd_valid, cmd_op, cmd_row, cmd_col_lo, cmd_col_hi}),
          64'({1'b1, 1'b1, 2'b10, 12'd0, 12'd0, 12'(GS - 1)}));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    obs_q.delete();
    obs_cyc.delete();

    // Simultaneous instruction and EOF: instruction first, then sweep.
    d = mk(0, 1, 3, 7, 3, 7, 3);
    model_instr(d);
    send(d, 1'b1);
    tick();
    compare_cmds("simul");
    check("simul_then_sweep", 64'({busy, cmd_op, cmd_row}), 64'({1'b1, 2'b10, 12'd0}));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    obs_q.delete();
    obs_cyc.delete();

    // Last-bit instruction enters SWEEP; reset at row 500 aborts.
    d = mk(1, 1, 0, 10, 0, 10, 0);
    model_instr(d);
    model_sweep(499);
    send(d, 1'b0);
    k = 0;
    while (!(busy && cmd_op == 2'b10 && cmd_row == 12'd500) && k < 2000) begin
      tick();
      k++;
    end
    check("row500_timeout", 64'(k < 2000), 64'(1));
    reset = 1'b1;
    tick();
    check_reset_state("abort");
    reset = 1'b0;
    n = obs_q.size();
    repeat (5) tick();
    check("abort_no_more_cmds", 64'(obs_q.size()), 64'(n));
    compare_cmds("last_sweep");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
